// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between the bootloader and the
// core's MMIO byte channel. Each requester owns a 1-deep buffer; a small FSM
// grants one buffered byte at a time, launches it with a one-cycle tx_Start
// and follows the transmitter's tx_busy until the byte has gone out.
//
// Handshake semantics (cpu channel): a byte transfers on every rising edge
// where cpu_tx_valid && cpu_tx_ready; cpu_tx_ready is simply "cpu buffer
// empty" and never depends on cpu_tx_valid. The boot side has no ready: a
// boot_tx_start pulse that finds its buffer occupied is dropped and flagged.
module uart_tx_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,          // asynchronous, active low
  input  logic       boot_mode,
  input  logic       boot_tx_start,
  input  logic [7:0] boot_tx_data,
  output logic       boot_busy,
  input  logic       cpu_tx_valid,
  input  logic [7:0] cpu_tx_data,
  output logic       cpu_tx_ready,
  output logic       tx_Start,
  output logic [7:0] tx_Data,
  input  logic       tx_busy,
  output logic       owner,          // 0 = boot, 1 = cpu
  output logic       timeout_err,
  output logic       boot_overrun,
  output logic [1:0] dbg_state_o
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          boot_pend_q, boot_pend_d;
  logic [7:0]    boot_buf_q, boot_buf_d;
  logic          cpu_pend_q, cpu_pend_d;
  logic [7:0]    cpu_buf_q, cpu_buf_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          owner_q, owner_d;
  logic          timeout_err_q, timeout_err_d;
  logic          boot_overrun_q, boot_overrun_d;

  logic          grant;
  logic          win_cpu;
  logic          cpu_accept;

  assign cpu_tx_ready = !cpu_pend_q;
  assign cpu_accept   = cpu_tx_valid && !cpu_pend_q;
  assign boot_busy    = boot_pend_q | ((state_q != IDLE) && (owner_q == 1'b0));
  assign tx_Start     = tx_start_q;
  assign tx_Data      = tx_data_q;
  assign owner        = owner_q;
  assign timeout_err  = timeout_err_q;
  assign boot_overrun = boot_overrun_q;
  assign dbg_state_o  = state_q;

  // Arbitration: a grant happens from IDLE whenever anything is buffered.
  // With both buffered, boot_mode forces boot; otherwise the requester that
  // did not own the last grant wins.
  always_comb begin
    grant   = (state_q == IDLE) && (boot_pend_q || cpu_pend_q);
    win_cpu = cpu_pend_q;
    if (boot_pend_q && cpu_pend_q) begin
      win_cpu = boot_mode ? 1'b0 : !owner_q;
    end
  end

  // Next-state logic for the FSM, the launch registers and both buffers.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data_q;
    owner_d        = owner_q;
    timeout_err_d  = 1'b0;
    boot_pend_d    = boot_pend_q;
    boot_buf_d     = boot_buf_q;
    cpu_pend_d     = cpu_pend_q;
    cpu_buf_d      = cpu_buf_q;
    boot_overrun_d = boot_overrun_q;

    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d    = LAUNCH;
          tx_start_d = 1'b1;
          tx_data_d  = win_cpu ? cpu_buf_q : boot_buf_q;
          owner_d    = win_cpu;
          if (win_cpu) begin
            cpu_pend_d = 1'b0;
          end else begin
            boot_pend_d = 1'b0;
          end
        end
      end
      LAUNCH: begin
        state_d = WAIT_BUSY;
        cnt_d   = '0;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Transmitter never acknowledged: abandon the byte.
          state_d       = IDLE;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A new boot byte may land in the slot that is being granted this edge;
    // the load then wins over the clear. Otherwise an occupied slot drops it.
    if (boot_tx_start) begin
      if (!boot_pend_q || (grant && !win_cpu)) begin
        boot_pend_d = 1'b1;
        boot_buf_d  = boot_tx_data;
      end else begin
        boot_overrun_d = 1'b1;
      end
    end

    // The cpu slot can only accept when empty, so it never collides with a
    // grant of the same slot.
    if (cpu_accept) begin
      cpu_pend_d = 1'b1;
      cpu_buf_d  = cpu_tx_data;
    end
  end

  // State registers; reset discards buffers and any byte in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      boot_pend_q    <= 1'b0;
      boot_buf_q     <= 8'h00;
      cpu_pend_q     <= 1'b0;
      cpu_buf_q      <= 8'h00;
      tx_start_q     <= 1'b0;
      tx_data_q      <= 8'h00;
      owner_q        <= 1'b1;
      timeout_err_q  <= 1'b0;
      boot_overrun_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      boot_pend_q    <= boot_pend_d;
      boot_buf_q     <= boot_buf_d;
      cpu_pend_q     <= cpu_pend_d;
      cpu_buf_q      <= cpu_buf_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      owner_q        <= owner_d;
      timeout_err_q  <= timeout_err_d;
      boot_overrun_q <= boot_overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios, a transaction-level
// model compared every cycle, a UART responder and a log of launched bytes.
module tb_uart_tx_arbiter;

  localparam int TIMEOUT = 16;

  // ---------------- clock / reset / signals ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       boot_mode = 1'b0;
  logic       boot_tx_start = 1'b0;
  logic [7:0] boot_tx_data = 8'h00;
  logic       cpu_tx_valid = 1'b0;
  logic [7:0] cpu_tx_data = 8'h00;
  logic       tx_busy = 1'b0;
  logic       boot_busy, cpu_tx_ready, tx_Start, owner, timeout_err, boot_overrun;
  logic [7:0] tx_Data;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .boot_mode(boot_mode),
    .boot_tx_start(boot_tx_start), .boot_tx_data(boot_tx_data), .boot_busy(boot_busy),
    .cpu_tx_valid(cpu_tx_valid), .cpu_tx_data(cpu_tx_data), .cpu_tx_ready(cpu_tx_ready),
    .tx_Start(tx_Start), .tx_Data(tx_Data), .tx_busy(tx_busy),
    .owner(owner), .timeout_err(timeout_err), .boot_overrun(boot_overrun),
    .dbg_state_o(dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks buffered bytes and one transfer: launch cycle, waiting for busy
  // (with an age in cycles), then waiting for busy to drop.
  bit       m_bp = 0, m_cp = 0, m_active = 0, m_start = 0, m_seen = 0;
  bit       m_owner = 1, m_terr = 0, m_ovr = 0;
  logic [7:0] m_bbuf = 0, m_cbuf = 0, m_data = 0;
  int       m_age = 0;

  always @(posedge clk or negedge reset) begin
    bit g, wc, bp0, cp0;
    if (!reset) begin
      m_bp = 0; m_cp = 0; m_active = 0; m_start = 0; m_seen = 0;
      m_owner = 1; m_terr = 0; m_ovr = 0; m_data = 0; m_age = 0;
    end else begin
      bp0 = m_bp;
      cp0 = m_cp;
      g   = !m_active && (bp0 || cp0);
      if (bp0 && cp0) wc = boot_mode ? 1'b0 : (m_owner == 1'b0);
      else            wc = cp0;
      m_terr = 0;
      if (m_active) begin
        if (m_start) begin
          m_seen = 0;
          m_age  = 0;
        end else if (!m_seen) begin
          if (tx_busy) m_seen = 1;
          else begin
            m_age++;
            if (m_age == TIMEOUT) begin
              m_active = 0;
              m_terr   = 1;
            end
          end
        end else if (!tx_busy) begin
          m_active = 0;
        end
      end
      m_start = 0;
      if (g) begin
        m_active = 1;
        m_start  = 1;
        m_owner  = wc;
        m_data   = wc ? m_cbuf : m_bbuf;
        if (wc) m_cp = 0; else m_bp = 0;
      end
      if (boot_tx_start) begin
        if (!bp0 || (g && !wc)) begin
          m_bbuf = boot_tx_data;
          m_bp   = 1;
        end else m_ovr = 1;
      end
      if (cpu_tx_valid && !cp0) begin
        m_cbuf = cpu_tx_data;
        m_cp   = 1;
      end
    end
  end

  // ---------------- compare, monitor, UART responder ----------------
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  int start_cyc_q[$];
  int terr_cyc_q[$];
  bit tie0 = 0;
  int busy_len = 10;
  int rem = 0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      check("tx_Start",     tx_Start,     m_start);
      check("tx_Data",      tx_Data,      m_data);
      check("owner",        owner,        m_owner);
      check("cpu_tx_ready", cpu_tx_ready, !m_cp);
      check("boot_busy",    boot_busy,    m_bp | (m_active && !m_owner));
      check("timeout_err",  timeout_err,  m_terr);
      check("boot_overrun", boot_overrun, m_ovr);
      if (tx_Start) begin
        got_q.push_back({owner, tx_Data});
        start_cyc_q.push_back(cyc);
      end
      if (timeout_err) terr_cyc_q.push_back(cyc);
    end
    if (!reset || tie0) begin
      tx_busy = 1'b0;
      rem = 0;
    end else if (tx_Start) begin
      tx_busy = 1'b1;
      rem = busy_len;
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) tx_busy = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic boot_send(input logic [7:0] d);
    @(negedge clk);
    boot_tx_start = 1'b1;
    boot_tx_data  = d;
    @(negedge clk);
    boot_tx_start = 1'b0;
  endtask

  task automatic cpu_send(input logic [7:0] d);
    @(negedge clk);
    cpu_tx_valid = 1'b1;
    cpu_tx_data  = d;
    @(negedge clk);
    cpu_tx_valid = 1'b0;
  endtask

  task automatic both_send(input logic [7:0] b, input logic [7:0] c);
    @(negedge clk);
    boot_tx_start = 1'b1; boot_tx_data = b;
    cpu_tx_valid  = 1'b1; cpu_tx_data  = c;
    @(negedge clk);
    boot_tx_start = 1'b0;
    cpu_tx_valid  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    bit idle_now;
    idle_now = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      idle_now = (dbg_state == 2'd0) && !m_active && !m_bp && !m_cp && !tx_busy;
      if (idle_now) break;
    end
    check("wait_idle_bound", idle_now, 1'b1);
  endtask

  task automatic check_log(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({name, "_byte"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int bi, ci, n;
    #2 reset = 1'b0;
    #21;
    check("rst_tx_Start", tx_Start, 1'b0);
    check("rst_tx_Data", tx_Data, 8'h00);
    check("rst_owner", owner, 1'b1);
    check("rst_cpu_tx_ready", cpu_tx_ready, 1'b1);
    check("rst_boot_busy", boot_busy, 1'b0);
    check("rst_overrun", boot_overrun, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Boot byte at idle: tx_Start in the cycle after the second edge.
    @(negedge clk);
    boot_tx_start = 1'b1; boot_tx_data = 8'hA5;
    @(negedge clk);
    boot_tx_start = 1'b0;
    check("lat_busy_after_k", boot_busy, 1'b1);
    check("lat_no_start_k", tx_Start, 1'b0);
    @(negedge clk);
    check("lat_start_k1", tx_Start, 1'b1);
    check("lat_data_k1", tx_Data, 8'hA5);
    check("lat_owner_k1", owner, 1'b0);
    @(negedge clk);
    check("lat_start_width", tx_Start, 1'b0);
    check("lat_data_held", tx_Data, 8'hA5);
    wait_idle(100);
    check("a5_boot_busy_fall", boot_busy, 1'b0);
    exp_q.push_back({1'b0, 8'hA5});
    check_log("a5");

    // Both pending, boot_mode=1: boot first.
    boot_mode = 1'b1;
    both_send(8'h22, 8'h11);
    wait_idle(200);
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h11});
    check_log("prio_boot");

    // boot_mode=0 with owner=0: cpu first.
    boot_mode = 1'b0;
    boot_send(8'h44);
    wait_idle(100);
    both_send(8'h22, 8'h11);
    wait_idle(200);
    exp_q.push_back({1'b0, 8'h44});
    exp_q.push_back({1'b1, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    check_log("rr_cpu_first");

    // Continuous traffic from both: strict alternation, cpu first.
    bi = 0; ci = 0; n = 0;
    while ((bi < 6 || ci < 6 || boot_tx_start || cpu_tx_valid) && n < 600) begin
      @(negedge clk);
      n++;
      if (boot_tx_start) boot_tx_start = 1'b0;
      else if (bi < 6 && !boot_busy) begin
        boot_tx_data  = 8'(8'hB0 + bi);
        boot_tx_start = 1'b1;
        bi++;
      end
      if (cpu_tx_valid) cpu_tx_valid = 1'b0;
      else if (ci < 6 && cpu_tx_ready) begin
        cpu_tx_data  = 8'(8'hC0 + ci);
        cpu_tx_valid = 1'b1;
        ci++;
      end
    end
    check("traffic_bound", n < 600, 1'b1);
    wait_idle(200);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({1'b1, 8'(8'hC0 + i)});
      exp_q.push_back({1'b0, 8'(8'hB0 + i)});
    end
    check_log("alternate");
    check("alt_no_overrun", boot_overrun, 1'b0);

    // tx_busy tied low: timeout 16 cycles after entering WAIT_BUSY.
    tie0 = 1;
    start_cyc_q.delete();
    terr_cyc_q.delete();
    boot_send(8'h5A);
    cpu_send(8'h6B);
    n = 0;
    while (terr_cyc_q.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("to_pulses", terr_cyc_q.size(), 2);
    check("to_starts", start_cyc_q.size(), 2);
    if (terr_cyc_q.size() >= 2 && start_cyc_q.size() >= 2) begin
      check("to_delay_first", terr_cyc_q[0] - start_cyc_q[0], 17);
      check("to_next_launch", start_cyc_q[1] - terr_cyc_q[0], 1);
      check("to_delay_second", terr_cyc_q[1] - start_cyc_q[1], 17);
    end
    wait_idle(100);
    exp_q.push_back({1'b0, 8'h5A});
    exp_q.push_back({1'b1, 8'h6B});
    check_log("timeout");
    tie0 = 0;

    // Boot overrun: second buffered, third dropped, flag sticky.
    boot_send(8'h71);
    boot_send(8'h72);
    boot_send(8'h73);
    check("ovr_set", boot_overrun, 1'b1);
    wait_idle(200);
    check("ovr_sticky", boot_overrun, 1'b1);
    exp_q.push_back({1'b0, 8'h71});
    exp_q.push_back({1'b0, 8'h72});
    check_log("overrun");

    // Reset during WAIT_DONE with a cpu byte also buffered.
    boot_send(8'h81);
    cpu_send(8'h82);
    repeat (3) @(negedge clk);
    check("pre_rst_state", dbg_state, 2'd3);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_tx_Start", tx_Start, 1'b0);
    check("mid_rst_boot_busy", boot_busy, 1'b0);
    check("mid_rst_cpu_ready", cpu_tx_ready, 1'b1);
    check("mid_rst_overrun", boot_overrun, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    got_q.delete();
    exp_q.delete();
    repeat (30) @(negedge clk);
    check("post_rst_no_launch", got_q.size(), 0);
    check("post_rst_owner", owner, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
